// File: rtl/pipeline_serializer.sv
// pipeline_serializer: splits one wide valid/bp token into InWidth/OutWidth
// narrow beats, least-significant slice first, with no inter-token bubbles.
// Ports: clk, reset (sync, active-high), d/d_valid/d_bp (wide in),
//        q/q_valid/q_bp/q_last (narrow out).
module pipeline_serializer #(
  parameter string Name     = "",
  parameter int    InWidth  = 32,
  parameter int    OutWidth = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [InWidth-1:0]  d,
  input  logic                d_valid,
  output logic                d_bp,
  output logic [OutWidth-1:0] q,
  output logic                q_valid,
  input  logic                q_bp,
  output logic                q_last
);

  localparam int Ratio = InWidth / OutWidth;
  localparam int BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  if (InWidth <= 0 || OutWidth <= 0 || (InWidth % OutWidth) != 0) begin : g_bad
    $error("%s: InWidth must be a positive multiple of OutWidth", Name);
  end

  logic               r_valid;
  logic [BeatW-1:0]   r_beat;
  logic [InWidth-1:0] r_shreg;

  logic               w_nxt_valid;
  logic [BeatW-1:0]   w_nxt_beat;
  logic [InWidth-1:0] w_nxt_shreg;

  logic w_out_fire;
  logic w_last_fire;
  logic w_in_fire;
  logic w_d_bp;

  // d_bp depends on q_bp combinationally so the slot frees up in the
  // same cycle the final beat leaves.
  assign w_out_fire  = r_valid && !q_bp;
  assign w_last_fire = w_out_fire && (r_beat == LastBeat);
  assign w_d_bp      = r_valid && !w_last_fire;
  assign w_in_fire   = d_valid && !w_d_bp;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_beat  <= w_nxt_beat;
    end
  end

  // Data register carries no reset; its content is ignored while invalid.
  always_ff @(posedge clk) begin
    r_shreg <= w_nxt_shreg;
  end

  // Next-state logic
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_beat  = r_beat;
    w_nxt_shreg = r_shreg;
    if (w_in_fire) begin
      w_nxt_valid = 1'b1;
      w_nxt_beat  = '0;
      w_nxt_shreg = d;
    end else if (w_last_fire) begin
      w_nxt_valid = 1'b0;
      w_nxt_beat  = '0;
    end else if (w_out_fire) begin
      w_nxt_beat  = r_beat + 1'b1;
      w_nxt_shreg = r_shreg >> OutWidth;
    end
  end

  // Output logic
  always_comb begin
    q       = r_shreg[OutWidth-1:0];
    q_valid = r_valid;
    q_last  = r_valid && (r_beat == LastBeat);
    d_bp    = w_d_bp;
  end

endmodule

// File: tb/tb_pipeline_serializer.sv
// tb_pipeline_serializer: directed + random checks of pipeline_serializer
// (32->8 and 8->8) against a beat-queue reference model.
module tb_pipeline_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d;
  logic        d_valid;
  logic        d_bp;
  logic [7:0]  q;
  logic        q_valid;
  logic        q_bp;
  logic        q_last;

  logic [7:0]  d1;
  logic        dv1;
  logic        dbp1;
  logic [7:0]  q1;
  logic        qv1;
  logic        qbp1;
  logic        ql1;

  always #5 clk = ~clk;

  pipeline_serializer #(
    .Name("ser32"), .InWidth(32), .OutWidth(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .d(d), .d_valid(d_valid), .d_bp(d_bp),
    .q(q), .q_valid(q_valid), .q_bp(q_bp), .q_last(q_last)
  );

  pipeline_serializer #(
    .Name("ser8"), .InWidth(8), .OutWidth(8)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .d(d1), .d_valid(dv1), .d_bp(dbp1),
    .q(q1), .q_valid(qv1), .q_bp(qbp1), .q_last(ql1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining beats of the token in flight, with last flags.
  logic [7:0] mq[$];
  bit         ml[$];
  logic [7:0] mq1[$];
  bit         acc;
  bit         r1_stream;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    bit ev, ebp, ev1, ebp1;
    #1;
    ev   = (mq.size() != 0);
    ebp  = ev && !(ml[0] && !q_bp);
    ev1  = (mq1.size() != 0);
    ebp1 = ev1 && qbp1;
    chk({tag, ".q_valid"}, q_valid, ev);
    chk({tag, ".q_last"}, q_last, ev && ml[0]);
    chk({tag, ".d_bp"}, d_bp, ebp);
    if (ev) chk({tag, ".q"}, q, mq[0]);
    chk({tag, ".r1_valid"}, qv1, ev1);
    chk({tag, ".r1_last"}, ql1, ev1);
    chk({tag, ".r1_d_bp"}, dbp1, ebp1);
    if (ev1) chk({tag, ".r1_q"}, q1, mq1[0]);
    @(posedge clk);
    acc = 1'b0;
    if (reset) begin
      mq.delete();
      ml.delete();
      mq1.delete();
    end else begin
      if (ev && !q_bp) begin
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (d_valid && !ebp) begin
        acc = 1'b1;
        for (int i = 0; i < 4; i++) begin
          mq.push_back(d[8*i +: 8]);
          ml.push_back(i == 3);
        end
      end
      if (ev1 && !qbp1) void'(mq1.pop_front());
      if (dv1 && !ebp1) mq1.push_back(d1);
    end
    #1;
    d1 = 8'($urandom);
    if (r1_stream) begin
      dv1  = 1'b1;
      qbp1 = 1'b0;
    end else begin
      dv1  = 1'($urandom);
      qbp1 = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    reset = 1'b1; d = '0; d_valid = 1'b0; q_bp = 1'b0;
    d1 = '0; dv1 = 1'b0; qbp1 = 1'b0; r1_stream = 1'b0;
    @(posedge clk);
    #1;
    step("rst");
    reset = 1'b0;
    step("post_rst");

    // Single token, Ratio=1 streaming alongside
    r1_stream = 1'b1;
    d = 32'hDDCCBBAA; d_valid = 1'b1;
    step("single");
    d_valid = 1'b0;
    repeat (5) step("single");
    r1_stream = 1'b0;

    // Back-to-back tokens
    d = 32'h44332211; d_valid = 1'b1;
    step("b2b");
    d = 32'h88776655;
    repeat (4) step("b2b");
    d_valid = 1'b0;
    repeat (5) step("b2b");

    // Downstream stall on beat 2
    d = 32'hDDCCBBAA; d_valid = 1'b1;
    step("stall");
    d_valid = 1'b0;
    repeat (2) step("stall");
    q_bp = 1'b1;
    repeat (3) step("stall");
    q_bp = 1'b0;
    repeat (3) step("stall");

    // Stall on last beat with next token pending
    d = 32'hDDCCBBAA; d_valid = 1'b1;
    step("stall_last");
    d = 32'h13579BDF;
    repeat (3) step("stall_last");
    q_bp = 1'b1;
    repeat (2) step("stall_last");
    q_bp = 1'b0;
    step("stall_last");
    d_valid = 1'b0;
    repeat (5) step("stall_last");

    // Reset mid-token
    d = 32'hDDCCBBAA; d_valid = 1'b1;
    step("mid_rst");
    d_valid = 1'b0;
    repeat (2) step("mid_rst");
    reset = 1'b1;
    step("mid_rst");
    reset = 1'b0;
    d = 32'h01020304; d_valid = 1'b1;
    step("mid_rst");
    d_valid = 1'b0;
    repeat (5) step("mid_rst");

    // Random traffic; upstream holds its token until accepted
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!d_valid || acc || reset) begin
        d       = $urandom;
        d_valid = ($urandom_range(0, 3) != 0);
      end
      q_bp  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    reset = 1'b0; d_valid = 1'b0; q_bp = 1'b0;
    repeat (6) step("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
